// File: rtl/word_assembler_pkg.sv
// Shared types and constants for the byte-to-18-bit word assembler.
package word_assembler_pkg;

  localparam int unsigned WORD_W = 18;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned PAD_W  = 6;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned LO_W   = 2 * BYTE_W;
  localparam int unsigned TOP_W  = WORD_W - LO_W;

  typedef enum logic [1:0] {
    PH0 = 2'd0,
    PH1 = 2'd1,
    PH2 = 2'd2
  } phase_e;

  // Top bits of the third byte supply the word MSBs; the remaining bits are padding.
  function automatic logic [WORD_W-1:0] pack_word(input logic [BYTE_W-1:0] b2,
                                                  input logic [LO_W-1:0]   lo);
    return {b2[BYTE_W-1 -: TOP_W], lo};
  endfunction

endpackage

// File: rtl/word_assembler_if.sv
// Byte-in / word-out handshake bundle for word_assembler.
interface word_assembler_if;
  import word_assembler_pkg::*;

  logic [BYTE_W-1:0] byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              sync_clr;
  logic [WORD_W-1:0] word_out;
  logic              word_valid;
  logic              word_ready;
  logic [CNT_W-1:0]  word_count;
  logic              pad_err;

  modport master (
    output byte_in, byte_valid, sync_clr, word_ready,
    input  byte_ready, word_out, word_valid, word_count, pad_err
  );

  modport slave (
    input  byte_in, byte_valid, sync_clr, word_ready,
    output byte_ready, word_out, word_valid, word_count, pad_err
  );

endinterface

// File: rtl/word_assembler_fifo.sv
// word_fifo: small synchronous FIFO for assembled words; DEPTH must be a power of two.
module word_fifo #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A push into a full buffer is legal only when a pop frees the head slot on the same edge.
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/word_assembler.sv
// Packs three bytes into an 18-bit word and buffers words in a FIFO.
// Define WORD_ASSEMBLER_PAD_CHECK_EN to flag non-zero padding bits via sticky pad_err.
module word_assembler
  import word_assembler_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  word_assembler_if.slave  bus
);

  phase_e            state_q, state_d;
  logic [LO_W-1:0]   part_q, part_d;
  logic [CNT_W-1:0]  word_count_q, word_count_d;
  logic              byte_ready;
  logic              accept, push, pop;
  logic              fifo_full, fifo_empty;
  logic [WORD_W-1:0] fifo_head;

  assign accept = bus.byte_valid && byte_ready;
  // sync_clr wins over a coincident accept, so the PH2 byte is dropped rather than pushed.
  assign push   = accept && !bus.sync_clr && (state_q == PH2);
  assign pop    = bus.word_ready && !fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= PH0;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.sync_clr) begin
      state_d = PH0;
    end else if (accept) begin
      case (state_q)
        PH0:     state_d = PH1;
        PH1:     state_d = PH2;
        PH2:     state_d = PH0;
        default: state_d = PH0;
      endcase
    end
  end

  always_comb begin
    byte_ready = 1'b1;
    if (state_q == PH2) byte_ready = !fifo_full || bus.word_ready;
  end

  always_comb begin
    part_d = part_q;
    if (bus.sync_clr) begin
      part_d = '0;
    end else if (accept) begin
      case (state_q)
        PH0:     part_d[BYTE_W-1:0]      = bus.byte_in;
        PH1:     part_d[LO_W-1:BYTE_W]   = bus.byte_in;
        default: part_d                  = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) part_q <= '0;
    else     part_q <= part_d;
  end

  assign word_count_d = word_count_q + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       word_count_q <= '0;
    else if (push) word_count_q <= word_count_d;
  end

  word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (pack_word(bus.byte_in, part_q)),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef WORD_ASSEMBLER_PAD_CHECK_EN
  logic pad_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      pad_err_q <= 1'b0;
    else if (push && (bus.byte_in[PAD_W-1:0] != '0)) pad_err_q <= 1'b1;
  end

  assign bus.pad_err = pad_err_q;
`else
  assign bus.pad_err = 1'b0;
`endif

  assign bus.byte_ready = byte_ready;
  assign bus.word_out   = fifo_head;
  assign bus.word_valid = !fifo_empty;
  assign bus.word_count = word_count_q;

endmodule

// File: tb/tb_word_assembler.sv
// Randomized scoreboard bench for word_assembler with a byte-list reference model.
module tb_word_assembler;
  import word_assembler_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  word_assembler_if ifc ();

  word_assembler #(.FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int          compared   = 0;
  int          mismatched = 0;
  logic [7:0]  pend [$];
  logic [17:0] exp_q [$];
  int unsigned exp_count = 0;
  bit          exp_pad = 1'b0;
  int unsigned rmode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    pend.delete();
    exp_q.delete();
    exp_count = 0;
    exp_pad   = 1'b0;
  endtask

  // Reference model: collect accepted bytes, emit a word on every third one.
  task automatic model_byte(input logic [7:0] b);
    int unsigned w;
    pend.push_back(b);
    if (pend.size() == 3) begin
      w = (int'(pend[2]) / 64) * 65536 + int'(pend[1]) * 256 + int'(pend[0]);
      exp_q.push_back(w[17:0]);
      exp_count = exp_count + 1;
`ifdef WORD_ASSEMBLER_PAD_CHECK_EN
      if ((pend[2] % 64) != 0) exp_pad = 1'b1;
`endif
      pend.delete();
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       ifc.word_ready = 1'b1;
      1:       ifc.word_ready = 1'($urandom_range(1));
      default: ifc.word_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("word_valid", 32'(ifc.word_valid), 32'(exp_q.size() != 0));
      check("byte_ready", 32'(ifc.byte_ready),
            (pend.size() == 2) ? 32'((exp_q.size() < DEPTH) || ifc.word_ready) : 32'd1);
      check("word_count", 32'(ifc.word_count), exp_count % 65536);
      check("pad_err", 32'(ifc.pad_err), 32'(exp_pad));
      if (ifc.word_valid && ifc.word_ready) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_word: got 0x%0h expected none at %0t", ifc.word_out, $time);
        end else begin
          check("word_out", 32'(ifc.word_out), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the byte was taken (or dropped by clr).
  task automatic send(input logic [7:0] b, input bit clr);
    bit done = 1'b0;
    int unsigned waited = 0;
    ifc.byte_in    = b;
    ifc.byte_valid = 1'b1;
    ifc.sync_clr   = clr;
    while (!done) begin
      @(negedge clk);
      #1;
      if (clr) begin
        pend.delete();
        done = 1'b1;
      end else if (ifc.byte_valid && ifc.byte_ready) begin
        model_byte(b);
        done = 1'b1;
      end else if (++waited > 100) begin
        check("send_timeout", 32'd1, 32'd0);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    ifc.byte_valid = 1'b0;
    ifc.sync_clr   = 1'b0;
  endtask

  task automatic clr_pulse();
    ifc.sync_clr = 1'b1;
    @(negedge clk);
    #1 pend.delete();
    @(posedge clk);
    #1 ifc.sync_clr = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int unsigned n = 0;
    rmode = 0;
    while (exp_q.size() != 0 && n < 50) begin
      idle(1);
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_state();
    check("rst_word_valid", 32'(ifc.word_valid), 32'd0);
    check("rst_word_out", 32'(ifc.word_out), 32'd0);
    check("rst_word_count", 32'(ifc.word_count), 32'd0);
    check("rst_byte_ready", 32'(ifc.byte_ready), 32'd1);
    check("rst_pad_err", 32'(ifc.pad_err), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_clear();
    #1 check_reset_state();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    ifc.byte_in    = '0;
    ifc.byte_valid = 1'b0;
    ifc.sync_clr   = 1'b0;
    ifc.word_ready = 1'b1;
    #2 check_reset_state();
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic assembly: 0x34,0x12,0xC0 -> 0x31234
    rmode = 0;
    send(8'h34, 0); send(8'h12, 0); send(8'hC0, 0);
    drain();
    check("count_after_first", 32'(ifc.word_count), 32'd1);

    // Backpressure: two words fill the buffer, third word's PH2 byte stalls
    rmode = 2;
    idle(1);
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0);
    send(8'h04, 0); send(8'h05, 0); send(8'h06, 0);
    send(8'h07, 0); send(8'h08, 0);
    fork
      send(8'h49, 0);
      begin
        repeat (4) @(negedge clk);
        check("stall_byte_ready", 32'(ifc.byte_ready), 32'd0);
        rmode = 1;
      end
    join
    drain();

    // sync_clr discards a partial word, including a coincident byte
    send(8'hAA, 0); send(8'hBB, 0);
    clr_pulse();
    send(8'h01, 0); send(8'h02, 0); send(8'h40, 0);
    send(8'h77, 0); send(8'h55, 1);
    send(8'h11, 0); send(8'h22, 0); send(8'h80, 0);
    drain();

    // Reset mid-word
    send(8'h11, 0); send(8'h22, 0);
    do_reset();
    send(8'h00, 0); send(8'h00, 0); send(8'h80, 0);
    drain();
    check("count_after_rst", 32'(ifc.word_count), 32'd1);

    // Non-zero padding bits
    send(8'h01, 0); send(8'h02, 0); send(8'hC1, 0);
    drain();
`ifdef WORD_ASSEMBLER_PAD_CHECK_EN
    check("pad_err_set", 32'(ifc.pad_err), 32'd1);
`else
    check("pad_err_tied", 32'(ifc.pad_err), 32'd0);
`endif

    // Randomized traffic
    rmode = 1;
    for (int i = 0; i < 400; i++) begin
      send(8'($urandom), ($urandom_range(15) == 0));
      if ($urandom_range(3) == 0) idle($urandom_range(3, 1));
    end
    drain();

    // word_count wrap
    force dut.word_count_q = 16'hFFFD;
    #1 release dut.word_count_q;
    exp_count = 32'hFFFD;
    for (int k = 0; k < 3; k++) begin
      send(8'($urandom), 0); send(8'($urandom), 0); send(8'h00, 0);
      drain();
    end
    check("count_wrapped", 32'(ifc.word_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/word_assembler.md
WORD_ASSEMBLER -- requirements
Module: word_assembler

Interface
REQ-001 Parameter FIFO_DEPTH, default 2, number of assembled 18-bit words buffered (power of two, >=2) SHALL be supported.
REQ-002 clk  input  1  sole clock, all state SHALL update on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 byte_in  input  8  byte from the 3-cycle byte serializer stage.
REQ-005 byte_valid  input  1  byte_in holds a valid byte.
REQ-006 byte_ready  output  1  block accepts byte_in this cycle.
REQ-007 sync_clr  input  1  discards any partial word; next accepted byte is byte 0.
REQ-008 word_out  output  18  head-of-buffer assembled word.
REQ-009 word_valid  output  1  word_out valid.
REQ-010 word_ready  input  1  downstream consumes word_out.
REQ-011 word_count  output  16  total words pushed, wraps 0xFFFF->0x0000.
REQ-012 pad_err  output  1  sticky padding error (REQ-026).

Function
REQ-013 A byte SHALL be accepted on a rising edge where byte_valid && byte_ready; a word SHALL be popped where word_valid && word_ready.
REQ-014 Phase FSM states SHALL be PH0, PH1, PH2; each accepted byte advances PH0->PH1->PH2->PH0; no accept = hold.
REQ-015 PH0 byte SHALL load word bits [7:0]; PH1 byte SHALL load bits [15:8]; PH2 byte bits [7:6] SHALL supply bits [17:16], bits [5:0] are padding and ignored.
REQ-016 Accepting the PH2 byte SHALL push the complete word into the buffer on the same edge; word_valid SHALL assert the following cycle (latency 1 cycle from third byte).
REQ-017 byte_ready SHALL be 1 in PH0/PH1, and in PH2 SHALL equal (!full || word_ready), permitting simultaneous push and pop when full.
REQ-018 word_valid SHALL equal buffer non-empty; word_out SHALL be stable while word_valid && !word_ready.
REQ-019 Buffer SHALL be FIFO-ordered; pointers SHALL wrap modulo FIFO_DEPTH; push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-020 sync_clr SHALL force PH0 and clear the partial-word register next edge, SHALL override a coincident byte accept (byte dropped), and SHALL NOT affect buffered words, word_count, or pad_err.
REQ-021 word_count SHALL increment by 1 on each push.

Reset
REQ-022 rst SHALL immediately force phase PH0, partial word 0, buffer empty, word_valid 0, word_out 0, word_count 0, pad_err 0.
REQ-023 byte_ready SHALL be 1 during and after reset (phase PH0).
REQ-024 rst asserted mid-word SHALL discard the partial word; no word SHALL be pushed from it.

Configuration
REQ-025 Macro WORD_ASSEMBLER_PAD_CHECK_EN SHALL select padding checking.
REQ-026 With macro defined: PH2 byte accepted with byte_in[5:0] != 0 SHALL set pad_err next cycle, held until rst; word still pushed unchanged.
REQ-027 Without macro: pad_err SHALL be tied 0 and no checking logic SHALL exist.

Structure
REQ-028 Package word_assembler_pkg SHALL hold the phase enum (PH0/PH1/PH2), WORD_W=18, BYTE_W=8, PAD_W=6 constants.
REQ-029 Buffer SHALL be a sub-module word_fifo (width WORD_W, depth FIFO_DEPTH, full/empty flags).

Verification
REQ-030 Bytes 0x34,0x12,0xC0 back-to-back, word_ready=1 -> word_out=0x31234, word_valid high exactly one cycle after third byte, word_count=1.
REQ-031 word_ready=0, stream 3 words (FIFO_DEPTH=2) -> third word's PH2 byte stalls with byte_ready=0 until one pop; words emerge in order.
REQ-032 Bytes 0xAA,0xBB then sync_clr, then 0x01,0x02,0x40 -> single word 0x10201, no word containing 0xBBAA.
REQ-033 rst asserted after PH1 byte, then 0x00,0x00,0x80 -> word 0x20000 only, word_count=1.
REQ-034 Macro defined, PH2 byte 0xC1 -> pad_err=1 next cycle, word 0x3xxxx still emitted; macro undefined -> pad_err stays 0.
REQ-035 Force word_count to 0xFFFF via pushes -> next push yields 0x0000.
